// File: rtl/multicycle_control_unit_if.sv
// Control/memory handshake bundle between the multi-cycle controller and
// the datapath plus shared instruction/data memory.
interface multicycle_control_unit_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] alu_op;
  logic       alu_src;
  logic       mem_2_reg;
  logic       reg_write;
  logic       branch;
  logic       jump;
  logic       ir_write;
  logic       pc_write;
  logic       fault;
  logic [2:0] state;

  // Controller side: consumes opcode/flags/ack, drives all control strobes.
  modport master (
    input  opcode, zero, mem_ack,
    output mem_req, mem_read, mem_write, alu_op, alu_src, mem_2_reg,
           reg_write, branch, jump, ir_write, pc_write, fault, state
  );

  // Datapath/memory side.
  modport slave (
    output opcode, zero, mem_ack,
    input  mem_req, mem_read, mem_write, alu_op, alu_src, mem_2_reg,
           reg_write, branch, jump, ir_write, pc_write, fault, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32 controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing,
// req/ack memory handshake with timeout, sticky FAULT on illegal opcode or
// memory timeout.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter bit          ENABLE_JUMP = 1'b1
) (
  input logic                         clk,
  input logic                         rst,
  multicycle_control_unit_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_R     = 3'd0,
    C_I     = 3'd1,
    C_LOAD  = 3'd2,
    C_STORE = 3'd3,
    C_BEQ   = 3'd4,
    C_JAL   = 3'd5
  } class_e;

  localparam int unsigned CW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // Wait count at which a further unacknowledged request cycle is the last one.
  localparam logic [CW-1:0] TO_LAST = (MEM_TIMEOUT == 0) ? CW'(0) : CW'(MEM_TIMEOUT - 1);

  state_e        state_q;
  class_e        class_q;
  logic [CW-1:0] wait_q;

  class_e dec_class;
  logic   dec_valid;
  logic   timeout_hit;

  // Opcode to instruction-class decode; used only while in DECODE.
  always_comb begin
    dec_class = C_R;
    dec_valid = 1'b1;
    case (bus.opcode)
      7'b0110011: dec_class = C_R;
      7'b0010011: dec_class = C_I;
      7'b0000011: dec_class = C_LOAD;
      7'b0100011: dec_class = C_STORE;
      7'b1100011: dec_class = C_BEQ;
      7'b1101111: begin
        dec_class = C_JAL;
        dec_valid = ENABLE_JUMP;
      end
      default:    dec_valid = 1'b0;
    endcase
  end

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == TO_LAST);

  // State, latched class and memory wait counter.
  // wait_q is cleared every cycle the FSM is not waiting, which is equivalent
  // to clearing it on entry to FETCH/MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      class_q <= C_R;
      wait_q  <= '0;
    end else begin
      wait_q <= '0;
      case (state_q)
        S_FETCH: begin
          if (bus.mem_ack)      state_q <= S_DECODE;
          else if (timeout_hit) state_q <= S_FAULT;
          else                  wait_q  <= wait_q + CW'(1);
        end
        S_DECODE: begin
          if (dec_valid) begin
            class_q <= dec_class;
            state_q <= S_EXECUTE;
          end else begin
            state_q <= S_FAULT;
          end
        end
        S_EXECUTE: begin
          case (class_q)
            C_LOAD, C_STORE: state_q <= S_MEM;
            C_BEQ:           state_q <= S_FETCH;
            default:         state_q <= S_WRITEBACK;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ack)      state_q <= (class_q == C_LOAD) ? S_WRITEBACK : S_FETCH;
          else if (timeout_hit) state_q <= S_FAULT;
          else                  wait_q  <= wait_q + CW'(1);
        end
        S_WRITEBACK: state_q <= S_FETCH;
        default:     state_q <= S_FAULT;
      endcase
    end
  end

  // Moore control decode from state/class; reset forces every output low.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.alu_op    = 2'b00;
    bus.alu_src   = 1'b0;
    bus.mem_2_reg = 1'b0;
    bus.reg_write = 1'b0;
    bus.branch    = 1'b0;
    bus.jump      = 1'b0;
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.fault     = 1'b0;
    bus.state     = 3'd0;
    if (!rst) begin
      bus.state = state_q;
      case (state_q)
        S_FETCH: begin
          bus.mem_req  = 1'b1;
          bus.mem_read = 1'b1;
          bus.ir_write = bus.mem_ack;
          bus.pc_write = bus.mem_ack;
        end
        S_EXECUTE: begin
          case (class_q)
            C_R:     bus.alu_op = 2'b10;
            C_I: begin
              bus.alu_op  = 2'b10;
              bus.alu_src = 1'b1;
            end
            C_LOAD, C_STORE: bus.alu_src = 1'b1;
            C_BEQ: begin
              bus.alu_op   = 2'b01;
              bus.branch   = 1'b1;
              bus.pc_write = bus.zero;
            end
            C_JAL: begin
              bus.jump     = 1'b1;
              bus.pc_write = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.mem_req   = 1'b1;
          bus.mem_read  = (class_q == C_LOAD);
          bus.mem_write = (class_q == C_STORE);
        end
        S_WRITEBACK: begin
          bus.reg_write = 1'b1;
          bus.mem_2_reg = (class_q == C_LOAD);
        end
        S_FAULT: bus.fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one DUT with default
// parameters, one with jumps disabled. Outputs are packed as
// {req,rd,wr,alu_op[1:0],src,m2r,rw,br,j,ir,pc,fault,state[2:0]}.
module tb_multicycle_control_unit;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  multicycle_control_unit_if bus1 ();
  multicycle_control_unit_if bus2 ();

  multicycle_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  multicycle_control_unit #(
    .MEM_TIMEOUT (15),
    .ENABLE_JUMP (1'b0)
  ) dut_nojump (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  logic [15:0] outs1;
  logic [15:0] outs2;
  assign outs1 = {bus1.mem_req, bus1.mem_read, bus1.mem_write, bus1.alu_op, bus1.alu_src,
                  bus1.mem_2_reg, bus1.reg_write, bus1.branch, bus1.jump, bus1.ir_write,
                  bus1.pc_write, bus1.fault, bus1.state};
  assign outs2 = {bus2.mem_req, bus2.mem_read, bus2.mem_write, bus2.alu_op, bus2.alu_src,
                  bus2.mem_2_reg, bus2.reg_write, bus2.branch, bus2.jump, bus2.ir_write,
                  bus2.pc_write, bus2.fault, bus2.state};

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  //                                     rq rd wr alu src m2r rw br j ir pc f st
  localparam logic [15:0] E_ZERO      = 16'b0_0_0_00_0_0_0_0_0_0_0_0_000;
  localparam logic [15:0] E_FETCH     = 16'b1_1_0_00_0_0_0_0_0_0_0_0_000;
  localparam logic [15:0] E_FETCH_ACK = 16'b1_1_0_00_0_0_0_0_0_1_1_0_000;
  localparam logic [15:0] E_DECODE    = 16'b0_0_0_00_0_0_0_0_0_0_0_0_001;
  localparam logic [15:0] E_EX_R      = 16'b0_0_0_10_0_0_0_0_0_0_0_0_010;
  localparam logic [15:0] E_EX_I      = 16'b0_0_0_10_1_0_0_0_0_0_0_0_010;
  localparam logic [15:0] E_EX_LS     = 16'b0_0_0_00_1_0_0_0_0_0_0_0_010;
  localparam logic [15:0] E_EX_BEQ_T  = 16'b0_0_0_01_0_0_0_1_0_0_1_0_010;
  localparam logic [15:0] E_EX_BEQ_N  = 16'b0_0_0_01_0_0_0_1_0_0_0_0_010;
  localparam logic [15:0] E_EX_JAL    = 16'b0_0_0_00_0_0_0_0_1_0_1_0_010;
  localparam logic [15:0] E_MEM_LD    = 16'b1_1_0_00_0_0_0_0_0_0_0_0_011;
  localparam logic [15:0] E_MEM_ST    = 16'b1_0_1_00_0_0_0_0_0_0_0_0_011;
  localparam logic [15:0] E_WB        = 16'b0_0_0_00_0_0_1_0_0_0_0_0_100;
  localparam logic [15:0] E_WB_LD     = 16'b0_0_0_00_0_1_1_0_0_0_0_0_100;
  localparam logic [15:0] E_FAULT     = 16'b0_0_0_00_0_0_0_0_0_0_0_1_111;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset for two edges; returns at posedge+1 with the DUTs in FETCH.
  task automatic do_reset();
    rst = 1'b1;
    bus1.mem_ack = 1'b0; bus1.zero = 1'b0; bus1.opcode = OP_R;
    bus2.mem_ack = 1'b0; bus2.zero = 1'b0; bus2.opcode = OP_R;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus1.mem_ack = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (outs1 !== E_ZERO) begin
      miscompares++; $display("FAIL reset_hold: got %b, want %b", outs1, E_ZERO);
    end
    vectors++;
    if (outs2 !== E_ZERO) begin
      miscompares++; $display("FAIL reset_hold_nj: got %b, want %b", outs2, E_ZERO);
    end
    bus1.mem_ack = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if (outs1 !== E_FETCH) begin
      miscompares++; $display("FAIL reset_release: got %b, want %b", outs1, E_FETCH);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [24:0] v [5];
    v = '{{OP_R, 2'b10, E_FETCH_ACK}, {OP_R, 2'b10, E_DECODE}, {OP_R, 2'b10, E_EX_R},
          {OP_R, 2'b10, E_WB},        {OP_R, 2'b00, E_FETCH}};
    foreach (v[i]) begin
      bus1.opcode = v[i][24:18]; bus1.mem_ack = v[i][17]; bus1.zero = v[i][16];
      #1;
      vectors++;
      if (outs1 !== v[i][15:0]) begin
        miscompares++; $display("FAIL rtype[%0d]: got %b, want %b", i, outs1, v[i][15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    logic [24:0] v [9];
    v = '{{OP_LD, 2'b10, E_FETCH_ACK}, {OP_LD, 2'b00, E_DECODE}, {OP_LD, 2'b00, E_EX_LS},
          {OP_LD, 2'b00, E_MEM_LD},    {OP_LD, 2'b00, E_MEM_LD}, {OP_LD, 2'b00, E_MEM_LD},
          {OP_LD, 2'b10, E_MEM_LD},    {OP_LD, 2'b00, E_WB_LD},  {OP_LD, 2'b00, E_FETCH}};
    foreach (v[i]) begin
      bus1.opcode = v[i][24:18]; bus1.mem_ack = v[i][17]; bus1.zero = v[i][16];
      #1;
      vectors++;
      if (outs1 !== v[i][15:0]) begin
        miscompares++; $display("FAIL load_wait[%0d]: got %b, want %b", i, outs1, v[i][15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    logic [24:0] v [7];
    v = '{{OP_BEQ, 2'b10, E_FETCH_ACK}, {OP_BEQ, 2'b01, E_DECODE}, {OP_BEQ, 2'b01, E_EX_BEQ_T},
          {OP_BEQ, 2'b10, E_FETCH_ACK}, {OP_BEQ, 2'b00, E_DECODE}, {OP_BEQ, 2'b00, E_EX_BEQ_N},
          {OP_BEQ, 2'b00, E_FETCH}};
    foreach (v[i]) begin
      bus1.opcode = v[i][24:18]; bus1.mem_ack = v[i][17]; bus1.zero = v[i][16];
      #1;
      vectors++;
      if (outs1 !== v[i][15:0]) begin
        miscompares++; $display("FAIL beq[%0d]: got %b, want %b", i, outs1, v[i][15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] v [13];
    v = '{{OP_I,   2'b10, E_FETCH_ACK}, {OP_I,   2'b00, E_DECODE}, {OP_I,   2'b00, E_EX_I},
          {OP_I,   2'b00, E_WB},
          {OP_ST,  2'b10, E_FETCH_ACK}, {OP_ST,  2'b00, E_DECODE}, {OP_ST,  2'b00, E_EX_LS},
          {OP_ST,  2'b10, E_MEM_ST},
          {OP_JAL, 2'b10, E_FETCH_ACK}, {OP_JAL, 2'b00, E_DECODE}, {OP_JAL, 2'b00, E_EX_JAL},
          {OP_JAL, 2'b00, E_WB},        {OP_JAL, 2'b00, E_FETCH}};
    foreach (v[i]) begin
      bus1.opcode = v[i][24:18]; bus1.mem_ack = v[i][17]; bus1.zero = v[i][16];
      #1;
      vectors++;
      if (outs1 !== v[i][15:0]) begin
        miscompares++; $display("FAIL back_to_back[%0d]: got %b, want %b", i, outs1, v[i][15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    bus1.opcode = OP_BAD; bus1.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus1.mem_ack = 1'b0;
    #1;
    vectors++;
    if (outs1 !== E_DECODE) begin
      miscompares++; $display("FAIL illegal_decode: got %b, want %b", outs1, E_DECODE);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      bus1.mem_ack = i[0];
      #1;
      vectors++;
      if (outs1 !== E_FAULT) begin
        miscompares++; $display("FAIL illegal_fault[%0d]: got %b, want %b", i, outs1, E_FAULT);
      end
      @(posedge clk); #1;
    end
    bus1.mem_ack = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (outs1 !== E_ZERO) begin
      miscompares++; $display("FAIL illegal_rst: got %b, want %b", outs1, E_ZERO);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (outs1 !== E_FETCH) begin
      miscompares++; $display("FAIL illegal_recover: got %b, want %b", outs1, E_FETCH);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_jal_disabled();
    bus2.opcode = OP_JAL; bus2.mem_ack = 1'b1;
    #1;
    vectors++;
    if (outs2 !== E_FETCH_ACK) begin
      miscompares++; $display("FAIL nojump_fetch: got %b, want %b", outs2, E_FETCH_ACK);
    end
    @(posedge clk); #1;
    bus2.mem_ack = 1'b0;
    #1;
    vectors++;
    if (outs2 !== E_DECODE) begin
      miscompares++; $display("FAIL nojump_decode: got %b, want %b", outs2, E_DECODE);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      #1;
      vectors++;
      if (outs2 !== E_FAULT) begin
        miscompares++; $display("FAIL nojump_fault[%0d]: got %b, want %b", i, outs2, E_FAULT);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (outs2 !== E_FETCH) begin
      miscompares++; $display("FAIL nojump_recover: got %b, want %b", outs2, E_FETCH);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    bus1.opcode = OP_R; bus1.mem_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      vectors++;
      if (outs1 !== E_FETCH) begin
        miscompares++; $display("FAIL timeout_wait[%0d]: got %b, want %b", i, outs1, E_FETCH);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (outs1 !== E_FAULT) begin
      miscompares++; $display("FAIL timeout_fault: got %b, want %b", outs1, E_FAULT);
    end
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus1.mem_ack = (i == 14);
      #1;
      vectors++;
      if (outs1 !== ((i == 14) ? E_FETCH_ACK : E_FETCH)) begin
        miscompares++;
        $display("FAIL timeout_last[%0d]: got %b, want %b", i, outs1,
                 (i == 14) ? E_FETCH_ACK : E_FETCH);
      end
      @(posedge clk); #1;
    end
    bus1.mem_ack = 1'b0;
    #1;
    vectors++;
    if (outs1 !== E_DECODE) begin
      miscompares++; $display("FAIL timeout_last_decode: got %b, want %b", outs1, E_DECODE);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_reset();
    logic [24:0] v [4];
    v = '{{OP_ST, 2'b10, E_FETCH_ACK}, {OP_ST, 2'b00, E_DECODE}, {OP_ST, 2'b00, E_EX_LS},
          {OP_ST, 2'b00, E_MEM_ST}};
    foreach (v[i]) begin
      bus1.opcode = v[i][24:18]; bus1.mem_ack = v[i][17]; bus1.zero = v[i][16];
      #1;
      vectors++;
      if (outs1 !== v[i][15:0]) begin
        miscompares++; $display("FAIL store_rst[%0d]: got %b, want %b", i, outs1, v[i][15:0]);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (outs1 !== E_ZERO) begin
      miscompares++; $display("FAIL store_rst_cycle: got %b, want %b", outs1, E_ZERO);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (outs1 !== E_FETCH) begin
        miscompares++; $display("FAIL store_rst_after[%0d]: got %b, want %b", i, outs1, E_FETCH);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    do_reset();
    test_reset();
    do_reset();
    test_rtype();
    do_reset();
    test_load_wait();
    do_reset();
    test_beq();
    do_reset();
    test_back_to_back();
    do_reset();
    test_illegal();
    do_reset();
    test_jal_disabled();
    do_reset();
    test_timeout();
    do_reset();
    test_store_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Finite-state controller for the multi-cycle RV32 datapath. It sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK states. It performs a req/ack handshake with a shared instruction/data memory and enforces a parametrised memory timeout. Illegal opcodes and memory timeouts drive it into a sticky FAULT state. It replaces the single-cycle combinational control decoder and drives the same datapath control signals, plus IR/PC write enables.

## Interface
- MEM_TIMEOUT, default 15: maximum number of consecutive wait cycles for mem_ack in FETCH/MEM; 0 disables the timeout.
- ENABLE_JUMP, default 1: when 0, JUMP (1101111) is treated as an illegal opcode.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- opcode  input  7  instruction opcode from the IR; sampled in DECODE only.
- zero  input  1  ALU zero flag; sampled in EXECUTE for BRANCH_EQ.
- mem_ack  input  1  memory completion; meaningful only while mem_req=1.
- mem_req  output  1  memory access request.
- mem_read  output  1  memory read strobe (instruction fetch or load).
- mem_write  output  1  memory write strobe (store).
- alu_op  output  2  00=add, 01=sub, 10=funct-decoded.
- alu_src  output  1  1 selects the immediate as ALU operand B.
- mem_2_reg  output  1  1 selects memory data as the register write-back source.
- reg_write  output  1  register-file write enable.
- branch  output  1  a branch is being evaluated.
- jump  output  1  a jump target is being selected.
- ir_write  output  1  instruction register load enable.
- pc_write  output  1  PC load enable.
- fault  output  1  sticky error indication.
- state  output  3  current state: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, FAULT=7.

## Operation
- Instruction class is decoded in DECODE and latched into a class register: R (0110011), I (0010011), LOAD (0000011), STORE (0100011), BEQ (1100011), JAL (1101111). Later states use only the latched class.
- Outputs are Moore-decoded from state and class. Exceptions: pc_write and ir_write in FETCH depend on mem_ack, and pc_write in EXECUTE for BEQ depends on zero.
- Unless stated otherwise below, every output is 0.
- FETCH:
  - mem_req=1, mem_read=1, alu_op=00, alu_src=0.
  - On mem_ack: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE: one cycle. An illegal opcode goes to FAULT; anything else goes to EXECUTE.
- EXECUTE:
  - R: alu_src=0, alu_op=10, then go to WRITEBACK.
  - I: alu_src=1, alu_op=10, then go to WRITEBACK.
  - LOAD and STORE: alu_src=1, alu_op=00, then go to MEM.
  - BEQ: alu_src=0, alu_op=01, branch=1, pc_write=zero, then go to FETCH.
  - JAL: jump=1, pc_write=1, then go to WRITEBACK.
- MEM:
  - mem_req=1 in both cases; LOAD additionally drives mem_read=1, STORE drives mem_write=1.
  - On mem_ack, LOAD goes to WRITEBACK and STORE goes to FETCH. Otherwise stay in MEM.
- WRITEBACK: reg_write=1, mem_2_reg=1 for LOAD only, then go to FETCH.
- FAULT: fault=1 and all other outputs 0. The block stays in FAULT until rst.
- Timeout:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 without mem_ack.
  - mem_ack is accepted in wait cycles 1..MEM_TIMEOUT.
  - If the MEM_TIMEOUT-th cycle ends without mem_ack, go to FAULT.
  - Counter width is clog2(MEM_TIMEOUT+1), minimum 1 bit.
- A mem_ack received while mem_req=0 is ignored.

## Timing
- Reset:
  - rst is sampled on the rising edge.
  - The next state is FETCH, the wait counter and class register are 0, and fault=0.
  - While rst=1, all outputs are forced to 0, including mem_req. state reads 0.
- The first mem_req is asserted in the first cycle with rst=0.
- rst asserted in any state, including mid-wait or FAULT, aborts the instruction. No write strobe may be asserted in the cycle rst is high.
- Latency with zero-wait memory (mem_ack in the first request cycle), in cycles per instruction:
  - R, I, STORE, JAL: 4
  - LOAD: 5
  - BEQ: 3
- Each memory wait cycle adds 1 cycle.
- Write strobes (reg_write, mem_write, pc_write, ir_write) are asserted for exactly one accepted cycle per instruction phase. The exception is mem_write, which stays high for the whole MEM handshake.

## Test plan
- Reset then R-type, ack in first cycle:
  - Expected state sequence 0,1,2,4,0.
  - ir_write and pc_write pulse at cycle 0, alu_op=10 at cycle 2, reg_write=1 at cycle 3 only.
- LOAD with mem_ack delayed 3 cycles in MEM:
  - MEM lasts 4 cycles with mem_read=1 throughout.
  - WRITEBACK follows with mem_2_reg=1 and reg_write=1.
  - Total 8 cycles.
- BEQ with zero=1, then BEQ with zero=0:
  - pc_write=1 in EXECUTE for the first and 0 for the second.
  - alu_op=01 and branch=1 in both; each takes 3 cycles.
- Illegal opcode 0000000, and JAL with ENABLE_JUMP=0:
  - FAULT after DECODE; fault=1 and state=7 held for 20 cycles.
  - Asserting rst returns the block to FETCH with fault=0.
- MEM_TIMEOUT=15, no mem_ack in FETCH:
  - FAULT is entered on the edge after the 15th request cycle.
  - Repeat with mem_ack on the 15th cycle: the block reaches DECODE with no fault.
- STORE with rst asserted during the 2nd MEM wait cycle:
  - mem_write=0 and mem_req=0 in the reset cycle.
  - The next cycle is FETCH with mem_req=1; no reg_write occurs.
